hedios_tx_arbiter: RTL
======================

HEDIOS_TX_ARBITER -- requirements
Module: hedios_tx_arbiter

Interface
REQ-001 SHALL take parameters (name, default, meaning): REQ_COUNT, 3, number of packet requesters sharing the serial TX queue (2..8).
REQ-002 SHALL take parameter STALL_LIMIT, 1024, consecutive full-queue cycles before stall_flag asserts (1..65535).
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  REQ_COUNT  per-requester packet pending.
REQ-006 SHALL have port req_command  in  REQ_COUNT x 8  per-requester packet command byte.
REQ-007 SHALL have port req_data  in  REQ_COUNT x 32  per-requester packet data word.
REQ-008 SHALL have port req_ready  out  REQ_COUNT  one-cycle capture acknowledge per requester.
REQ-009 SHALL have port tx_full  in  1  serial TX queue full.
REQ-010 SHALL have ports tx_command  out  8  and tx_data  out  32  packet presented to the TX queue.
REQ-011 SHALL have port tx_push_packet  out  1  TX queue push strobe.
REQ-012 SHALL have ports grant_id  out  $clog2(REQ_COUNT)  last granted index, busy  out  1  packet held, stall_flag  out  1  TX stalled past STALL_LIMIT.

Function
REQ-013 SHALL implement FSM states IDLE and SEND only.
REQ-014 In IDLE with any req_valid high, SHALL pick the first valid index searching round-robin from grant_id+1 modulo REQ_COUNT, capture its command/data into holding registers, pulse that req_ready bit for exactly that cycle, update grant_id, and enter SEND.
REQ-015 In IDLE with no req_valid, SHALL remain in IDLE with all req_ready low.
REQ-016 At most one req_ready bit SHALL be high in any cycle, and only in IDLE.
REQ-017 Requesters hold valid/command/data stable until their req_ready; a valid dropped before ready SHALL be treated as withdrawn, not an error.
REQ-018 tx_command/tx_data SHALL always drive the holding registers.
REQ-019 tx_push_packet SHALL be combinational: high iff state is SEND and tx_full is low.
REQ-020 On a SEND cycle with tx_push_packet high, SHALL return to IDLE next cycle; otherwise remain in SEND with holding registers unchanged.
REQ-021 Capture-to-push latency SHALL be 1 cycle with tx_full low; peak throughput SHALL be one packet per 2 cycles.
REQ-022 busy SHALL equal (state == SEND).
REQ-023 stall counter (16 bit) SHALL increment each SEND cycle with tx_full high, saturate at 16'hFFFF, and clear on push or in IDLE.
REQ-024 stall_flag SHALL be high while stall counter >= STALL_LIMIT and clear in the cycle after the push.
REQ-025 A requester re-asserting valid immediately after its grant SHALL not win again while any other requester is valid (no starvation; worst-case wait = REQ_COUNT-1 packets).

Reset
REQ-026 While rst is low SHALL force: state IDLE, grant_id = REQ_COUNT-1 (so index 0 wins first), holding registers 0, stall counter 0, req_ready 0, tx_push_packet 0, busy 0, stall_flag 0.
REQ-027 Reset asserted in SEND SHALL discard the held packet; no push SHALL occur for it after release.

Structure
REQ-028 FSM state encoding and the 8-bit command / 32-bit data width constants SHALL live in the shared hedios_pkg package, reused by the serial TX/RX blocks.
REQ-029 The round-robin next-index search SHALL be a sub-module hedios_rr_select (inputs valid vector, last index; outputs found, index), purely combinational.

Verification
REQ-030 Single request: req_valid=3'b010, cmd 8'hA5, data 32'hDEADBEEF, tx_full=0 -> req_ready[1] cycle N, push with A5/DEADBEEF cycle N+1, grant_id=1.
REQ-031 All valid after reset, held continuously -> grant order 0,1,2,0,1,2; pushes every 2nd cycle.
REQ-032 tx_full high for 5 cycles during SEND -> no push, outputs stable, busy=1; push the cycle tx_full drops; no second req_ready meanwhile.
REQ-033 STALL_LIMIT=4, tx_full held 6 cycles -> stall_flag rises once counter reaches 4, clears cycle after push.
REQ-034 rst low while SEND with tx_full=1, then released with tx_full=0 and no valid -> no push, all outputs at reset values, next grant is index 0.
REQ-035 Requester 0 re-asserts valid every cycle, requester 2 valid -> grants alternate 0,2,0,2.

Source files
------------

// File: rtl/hedios_pkg.sv
// Shared definitions for the HEDIOS serial blocks: packet field widths and
// the TX arbiter FSM encoding.
package hedios_pkg;

  localparam int CMD_W   = 8;
  localparam int DATA_W  = 32;
  localparam int STALL_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_arb_state_t;

endpackage

// File: rtl/hedios_rr_select.sv
// Round-robin search: first set bit of i_valid, starting one past i_last and
// wrapping modulo N. Purely combinational.
module hedios_rr_select #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_last,
  output logic          o_found,
  output logic [IW-1:0] o_index
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // i runs to N so the last winner is picked only when it is the sole valid one.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 1; i <= N; i++) begin
      w_sum  = {1'b0, i_last} + (IW+1)'(i);
      w_cand = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
      if (!o_found && i_valid[w_cand]) begin
        o_found = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/hedios_tx_arbiter.sv
// Round-robin arbiter feeding one serial TX queue: captures a packet from a
// requester in IDLE, then presents it in SEND until the queue accepts it.
module hedios_tx_arbiter
  import hedios_pkg::*;
#(
  parameter  int REQ_COUNT   = 3,
  parameter  int STALL_LIMIT = 1024,
  localparam int IDW         = $clog2(REQ_COUNT)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REQ_COUNT-1:0]               req_valid,
  input  logic [REQ_COUNT-1:0][CMD_W-1:0]    req_command,
  input  logic [REQ_COUNT-1:0][DATA_W-1:0]   req_data,
  output logic [REQ_COUNT-1:0]               req_ready,
  input  logic                               tx_full,
  output logic [CMD_W-1:0]                   tx_command,
  output logic [DATA_W-1:0]                  tx_data,
  output logic                               tx_push_packet,
  output logic [IDW-1:0]                     grant_id,
  output logic                               busy,
  output logic                               stall_flag
);

  // Handshake: req_ready is a one-cycle capture strobe raised only in IDLE for
  // the selected valid requester; tx_push_packet fires when SEND meets !tx_full.
  tx_arb_state_t     r_state;
  tx_arb_state_t     w_next_state;
  logic [IDW-1:0]    r_grant;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_data;
  logic [STALL_W-1:0] r_stall_cnt;
  logic              w_found;
  logic [IDW-1:0]    w_sel;
  logic              w_capture;

  hedios_rr_select #(.N(REQ_COUNT)) u_rr_select (
    .i_valid (req_valid),
    .i_last  (r_grant),
    .o_found (w_found),
    .o_index (w_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // rst gates the strobes so req_ready stays low for the whole reset window.
  always_comb begin
    w_next_state   = r_state;
    w_capture      = 1'b0;
    req_ready      = '0;
    tx_push_packet = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rst && w_found) begin
          w_capture        = 1'b1;
          req_ready[w_sel] = 1'b1;
          w_next_state     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_full) begin
          tx_push_packet = 1'b1;
          w_next_state   = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= IDW'(REQ_COUNT - 1);
      r_cmd   <= '0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_grant <= w_sel;
      r_cmd   <= req_command[w_sel];
      r_data  <= req_data[w_sel];
    end
  end

  // Counts consecutive blocked SEND cycles; any push or IDLE cycle clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (r_state == ST_SEND && tx_full) begin
      if (r_stall_cnt != {STALL_W{1'b1}}) r_stall_cnt <= r_stall_cnt + 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign tx_command = r_cmd;
  assign tx_data    = r_data;
  assign grant_id   = r_grant;
  assign busy       = (r_state == ST_SEND);
  assign stall_flag = (r_stall_cnt >= STALL_W'(STALL_LIMIT));

endmodule
